sim_uart_receiver: RTL
======================

SIM_UART_RECEIVER -- requirements
Module: sim_uart_receiver

Interface
REQ-001 SHALL have parameter ClockFrequency, default 125_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BaudRate, default 15_625_000, serial bit rate; ClksPerBit = ClockFrequency/BaudRate, integer division, SHALL be >= 4 (elaboration error otherwise).
REQ-003 SHALL have parameter FifoDepth, default 16, receive FIFO entries, power of two, >= 2.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 rx_i  input  1  serial line from the system's uart_tx_o, idle high, 8N1, LSB first.
REQ-008 data_o  output  8  head-of-FIFO byte, valid only while valid_o=1.
REQ-009 valid_o  output  1  FIFO non-empty.
REQ-010 ready_i  input  1  consumer accepts data_o when valid_o & ready_i on a rising edge.
REQ-011 frame_err_o  output  1  sticky, set on a stop bit sampled low.
REQ-012 overflow_o  output  1  sticky, set when a good byte arrives with FIFO full.
REQ-013 clear_i  input  1  synchronous clear of frame_err_o and overflow_o.
REQ-014 busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL pass rx_i through a 2-flop synchronizer (reset value 1); all sampling uses the synchronized value rx_s.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP with one bit-timer counter and a 3-bit bit index.
REQ-017 IDLE: on rx_s=0, load timer with ClksPerBit/2 - 1 and go to START.
REQ-018 START: at timer 0, if rx_s=0, load timer ClksPerBit-1, index 0, go to DATA; if rx_s=1 (glitch), return to IDLE, no status change.
REQ-019 DATA: at each timer 0, shift rx_s into bit[index] (LSB first) and reload ClksPerBit-1; after index 7, go to STOP.
REQ-020 STOP: at timer 0, if rx_s=1, push byte and return to IDLE; if rx_s=0, discard byte, set frame_err_o, go to IDLE only after rx_s returns to 1.
REQ-021 Push SHALL occur on the same edge the stop bit is sampled; valid_o SHALL rise on the following cycle.
REQ-022 FIFO pointers SHALL be log2(FifoDepth)+1 bits with wrap; full when MSBs differ and rest equal, empty when equal.
REQ-023 Pop on valid_o & ready_i; data_o SHALL present the next entry (or valid_o drop) the following cycle.
REQ-024 Push on full FIFO SHALL drop the byte and set overflow_o; FIFO contents unchanged.
REQ-025 Simultaneous push and pop on full FIFO SHALL accept both, no overflow; on empty FIFO, push SHALL be kept (no bypass to data_o same cycle).
REQ-026 clear_i SHALL clear sticky flags; a set event in the same cycle as clear_i SHALL win (flag stays 1).
REQ-027 Receiver SHALL never stall on FIFO state; reception continues while full.

Reset
REQ-028 During rst_i: FSM=IDLE, timer=0, index=0, synchronizer flops=1, FIFO pointers=0.
REQ-029 Reset values: data_o=0, valid_o=0, frame_err_o=0, overflow_o=0, busy_o=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no push; after release, a line held low SHALL not be taken as a start bit until it has been seen high at least once.

Verification (ClockFrequency=125_000_000, BaudRate=15_625_000, ClksPerBit=8, FifoDepth=4)
REQ-031 Drive 8N1 frame 0xA5, ready_i=0 -> valid_o=1, data_o=0xA5, frame_err_o=0, busy_o low after the stop bit is sampled.
REQ-032 Send 0x01,0x02,0x03,0x04,0x05 with ready_i=0 -> FIFO holds 0x01..0x04, overflow_o=1; pop four bytes in order, then valid_o=0.
REQ-033 Frame 0x3C with stop bit driven 0 -> no push, frame_err_o=1; clear_i pulse -> frame_err_o=0.
REQ-034 rx_i low pulse of 2 clocks in IDLE -> START aborts to IDLE, no push, no flags.
REQ-035 Assert rst_i at DATA bit 4 of 0xFF -> outputs at reset values, no byte ever appears; next frame 0x5A received correctly.
REQ-036 FIFO full, ready_i=1 on the stop-bit sample cycle of 0x77 -> overflow_o stays 0, 0x77 becomes last entry.

Source files
------------

// File: rtl/sim_uart_receiver.sv
// rtl/sim_uart_receiver.sv - 8N1 UART receiver with receive FIFO and sticky error flags
module sim_uart_receiver #(
  parameter int ClockFrequency = 125_000_000,
  parameter int BaudRate       = 15_625_000,
  parameter int FifoDepth      = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  input  logic       clear_i,
  output logic       busy_o
);

  localparam int ClksPerBit = ClockFrequency / BaudRate;
  localparam int TimerW     = $clog2(ClksPerBit);
  localparam int AddrW      = $clog2(FifoDepth);
  localparam int PtrW       = AddrW + 1;
  localparam logic [TimerW-1:0] HalfLoad = TimerW'(ClksPerBit / 2 - 1);
  localparam logic [TimerW-1:0] FullLoad = TimerW'(ClksPerBit - 1);

  generate
    if (ClksPerBit < 4) begin : g_bad_clks_per_bit
      $error("sim_uart_receiver: ClockFrequency/BaudRate must be at least 4");
    end
    if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : g_bad_fifo_depth
      $error("sim_uart_receiver: FifoDepth must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic              rx_meta, rx_s;
  logic [1:0]        flush_sr;
  logic              armed;
  logic [TimerW-1:0] timer;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              break_wait;
  logic              bit_tick;
  logic              push, frame_evt;

  logic [7:0]        mem [FifoDepth];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic              empty, full, pop, wr_en, ovf_evt;

  assign bit_tick = (timer == '0);

  // Two-flop synchronizer; armed only once the flushed line has been seen idle high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      flush_sr <= 2'b00;
      armed    <= 1'b0;
    end else begin
      rx_meta  <= rx_i;
      rx_s     <= rx_meta;
      flush_sr <= {flush_sr[0], 1'b1};
      armed    <= armed | (flush_sr[1] & rx_s);
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (armed && !rx_s) state_nxt = START;
      START:   if (bit_tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_tick && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_tick && rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: push a good byte or flag a framing error exactly once per frame
  always_comb begin
    push      = 1'b0;
    frame_evt = 1'b0;
    busy_o    = (state != IDLE);
    if (state == STOP && bit_tick && !break_wait) begin
      push      = rx_s;
      frame_evt = !rx_s;
    end
  end

  // Bit timer, bit index, shift register and break-wait tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      break_wait <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          break_wait <= 1'b0;
          if (armed && !rx_s) timer <= HalfLoad;
        end
        START: begin
          if (!bit_tick) timer <= timer - TimerW'(1);
          else if (!rx_s) begin
            timer   <= FullLoad;
            bit_idx <= 3'd0;
          end
        end
        DATA: begin
          if (!bit_tick) timer <= timer - TimerW'(1);
          else begin
            shreg[bit_idx] <= rx_s;
            timer          <= FullLoad;
            bit_idx        <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (!bit_tick) timer <= timer - TimerW'(1);
          else if (!rx_s) break_wait <= 1'b1;
        end
        default: timer <= '0;
      endcase
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                   (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
  assign valid_o = !empty;
  assign pop     = valid_o & ready_i;
  assign wr_en   = push & (!full | pop);
  assign ovf_evt = push & full & !pop;
  assign data_o  = valid_o ? mem[rd_ptr[AddrW-1:0]] : 8'h00;

  // FIFO storage; on full with a simultaneous pop the popped slot is reused
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AddrW-1:0]] <= shreg;
  end

  // FIFO pointers with wrap bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)   rd_ptr <= rd_ptr + PtrW'(1);
    end
  end

  // Sticky status flags; a new event beats a same-cycle clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      frame_err_o <= (frame_err_o & !clear_i) | frame_evt;
      overflow_o  <= (overflow_o & !clear_i) | ovf_evt;
    end
  end

endmodule
